// File: rtl/sr_using_t_bank.sv
// WIDTH-channel SR bank built from T flip-flops, with illegal S=R=1 monitoring.
// Optional macro SR_INVALID_TOGGLE_EN: S=R=1 toggles the channel (JK) instead of holding.

module sr_t_cell (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic s,
    input  logic r,
    input  logic clr_err,
    output logic q,
    output logic t,
    output logic err,
    output logic inv
);
    logic r_q;
    logic r_err;
    logic w_inv;
    logic w_t_sr;

    assign w_inv  = en & s & r;
    assign w_t_sr = en & ((s & ~r & ~r_q) | (r & ~s & r_q));
`ifdef SR_INVALID_TOGGLE_EN
    assign t = w_t_sr | w_inv;
`else
    assign t = w_t_sr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_q <= r_q ^ t;
            // Clear first, then record this cycle's event.
            if (clr_err) r_err <= w_inv;
            else         r_err <= r_err | w_inv;
        end
    end

    assign q   = r_q;
    assign err = r_err;
    assign inv = w_inv;
endmodule

module sr_using_t_bank #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    input  logic             clr_err,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] T,
    output logic [WIDTH-1:0] err_flag,
    output logic [CNT_W-1:0] err_cnt,
    output logic             changed
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] w_inv;
    logic [CNT_W-1:0] r_cnt;
    logic             r_changed;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        sr_t_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .s       (S[i]),
            .r       (R[i]),
            .clr_err (clr_err),
            .q       (Q[i]),
            .t       (T[i]),
            .err     (err_flag[i]),
            .inv     (w_inv[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_changed <= 1'b0;
        end else begin
            r_changed <= |T;
            if (clr_err)
                r_cnt <= (|w_inv) ? CNT_W'(1) : '0;
            else if ((|w_inv) && (r_cnt != CNT_MAX))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign err_cnt = r_cnt;
    assign changed = r_changed;
endmodule

// File: tb/tb_sr_using_t_bank.sv
// Scoreboard bench for sr_using_t_bank (WIDTH=8, CNT_W=4); handles both SR_INVALID_TOGGLE_EN builds.

module tb_sr_using_t_bank;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] S = '0;
    logic [7:0] R = '0;
    logic       clr_err = 1'b0;
    logic [7:0] Q, T, err_flag;
    logic [3:0] err_cnt;
    logic       changed;

    typedef struct {
        logic [7:0] q;
        logic [7:0] err;
        logic [3:0] cnt;
        logic       chg;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

`ifdef SR_INVALID_TOGGLE_EN
    localparam bit TOG = 1'b1;
`else
    localparam bit TOG = 1'b0;
`endif

    sr_using_t_bank #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .S(S), .R(R), .clr_err(clr_err),
        .Q(Q), .T(T), .err_flag(err_flag), .err_cnt(err_cnt), .changed(changed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: the bank answers every cycle, so one expectation is retired per edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("Q", Q, e.q);
            check("err_flag", err_flag, e.err);
            check("err_cnt", err_cnt, e.cnt);
            check("changed", changed, e.chg);
        end
    end

    task automatic step(input logic rs, input logic e_en, input logic [7:0] s, input logic [7:0] r,
                        input logic clr, input bit chk_t, input logic [7:0] et,
                        input logic [7:0] eq, input logic [7:0] eerr, input logic [3:0] ecnt,
                        input logic echg);
        exp_t e;
        @(negedge clk);
        rst = rs; en = e_en; S = s; R = r; clr_err = clr;
        #1;
        if (chk_t) check("T", T, et);
        e.q = eq; e.err = eerr; e.cnt = ecnt; e.chg = echg;
        exp_q.push_back(e);
    endtask

    initial begin
        logic [7:0] qd;
        logic [3:0] c;
        // Reset with S active, then basic set / hold
        step(1, 1, 8'hFF, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 4'd0, 0);
        step(0, 1, 8'h0F, 8'h00, 0, 1, 8'h0F, 8'h0F, 8'h00, 4'd0, 1);
        step(0, 1, 8'h0F, 8'h00, 0, 1, 8'h00, 8'h0F, 8'h00, 4'd0, 0);
        // Set/reset mix, then global disable
        step(0, 1, 8'hF0, 8'h03, 0, 1, 8'hF3, 8'hFC, 8'h00, 4'd0, 1);
        step(0, 0, 8'hFF, 8'h00, 0, 1, 8'h00, 8'hFC, 8'h00, 4'd0, 0);
        // Invalid S=R=1 on channels 7 and 0
        qd = TOG ? 8'h7D : 8'hFC;
        step(0, 1, 8'h81, 8'h81, 0, 1, TOG ? 8'h81 : 8'h00, qd, 8'h81, 4'd1, TOG);
        // Reset all channels via R
        step(0, 1, 8'h00, 8'hFF, 0, 1, qd, 8'h00, 8'h81, 4'd1, 1);
        // Clear errors, then saturate the counter
        step(0, 1, 8'h00, 8'h00, 1, 1, 8'h00, 8'h00, 8'h00, 4'd0, 0);
        qd = 8'h00;
        for (int k = 1; k <= 20; k++) begin
            c = (k > 15) ? 4'hF : 4'(k);
            qd = TOG ? (qd ^ 8'h01) : qd;
            step(0, 1, 8'h01, 8'h01, 0, 1, TOG ? 8'h01 : 8'h00, qd, 8'h01, c, TOG);
        end
        // Clear coinciding with a new invalid event
        qd = TOG ? (qd ^ 8'h02) : qd;
        step(0, 1, 8'h02, 8'h02, 1, 1, TOG ? 8'h02 : 8'h00, qd, 8'h02, 4'd1, TOG);
        // Reset mid-stream
        for (int k = 2; k <= 6; k++) begin
            qd = TOG ? (qd ^ 8'h01) : qd;
            step(0, 1, 8'h01, 8'h01, 0, 1, TOG ? 8'h01 : 8'h00, qd, 8'h03, 4'(k), TOG);
        end
        step(1, 1, 8'h01, 8'h01, 0, 0, 8'h00, 8'h00, 8'h00, 4'd0, 0);
        step(0, 1, 8'h01, 8'h01, 0, 1, TOG ? 8'h01 : 8'h00, TOG ? 8'h01 : 8'h00, 8'h01, 4'd1, TOG);
        qd = TOG ? 8'h01 : 8'h00;
        // clr_err works with en=0; S=R=1 ignored while disabled
        step(0, 0, 8'hFF, 8'hFF, 1, 1, 8'h00, qd, 8'h00, 4'd0, 0);
        step(0, 0, 8'hFF, 8'hFF, 0, 1, 8'h00, qd, 8'h00, 4'd0, 0);
        @(negedge clk);
        en = 0; S = 0; R = 0; clr_err = 0;
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
